// File: rtl/instruction_fetch_pkg.sv
// Definitions shared by the fetch stage, the program counter and the phase sequencer:
// processor phase codes and the default bus widths.
package instruction_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] PHASE_FETCH     = 3'b000;
  localparam logic [2:0] PHASE_DECODE    = 3'b001;
  localparam logic [2:0] PHASE_EXECUTE   = 3'b010;
  localparam logic [2:0] PHASE_MEMORY    = 3'b011;
  localparam logic [2:0] PHASE_WRITEBACK = 3'b100;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: registered req/addr from the fetch stage,
// single-cycle ack with read data from the memory.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the word at pc_in during the fetch phase, latches it into ir,
// stalls the phase sequencer until ir is valid, and flags a memory timeout.
//
//  state | meaning
//  IDLE  | no request outstanding; starts a fetch when phase is the fetch phase
//  WAIT  | mem_req high, waiting for mem_ack; watchdog counting
//  DONE  | ir valid for this fetch phase; returns to IDLE when the phase moves on
//  ERR   | memory timed out; fetch_err held until err_clr
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         DATA_W      = DATA_W_DEF,
  parameter int         TIMEOUT     = 15,
  parameter logic [2:0] FETCH_PHASE = PHASE_FETCH
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [2:0]         phase,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               err_clr,
  instruction_fetch_if.master mem,
  output logic [DATA_W-1:0]  ir,
  output logic               ir_valid,
  output logic               fetch_stall,
  output logic               fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] ir_nxt;
  logic              valid_nxt;
  logic              err_nxt;
  logic              in_fetch;

  assign in_fetch    = (phase == FETCH_PHASE);
  assign fetch_stall = in_fetch && (state != S_DONE);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      ir           <= '0;
      ir_valid     <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mem.mem_req  <= req_nxt;
      mem.mem_addr <= addr_nxt;
      ir           <= ir_nxt;
      ir_valid     <= valid_nxt;
      fetch_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = mem.mem_req;
    addr_nxt  = mem.mem_addr;
    ir_nxt    = ir;
    valid_nxt = ir_valid;
    err_nxt   = fetch_err;
    case (state)
      S_IDLE: begin
        if (in_fetch) begin
          addr_nxt  = pc_in;
          req_nxt   = 1'b1;
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // an ack on the last watchdog cycle still completes normally
        if (mem.mem_ack) begin
          ir_nxt    = mem.mem_rdata;
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            req_nxt   = 1'b0;
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
      S_DONE: begin
        if (!in_fetch) state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) begin
          err_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a spec-level model checked every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_instruction_fetch;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic [2:0]  phase = 3'b001;
  logic [15:0] pc_in = '0;
  logic        err_clr = 1'b0;
  logic [15:0] ir;
  logic        ir_valid, fetch_stall, fetch_err;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

  instruction_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT), .FETCH_PHASE(3'b000)) dut (
    .clock       (clock),
    .rst         (rst),
    .phase       (phase),
    .pc_in       (pc_in),
    .err_clr     (err_clr),
    .mem         (mem_bus.master),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .fetch_stall (fetch_stall),
    .fetch_err   (fetch_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the fetch stage has promised so far, in spec terms.
  bit          m_pending = 0;  // request outstanding
  bit          m_served  = 0;  // word already delivered in this fetch phase
  bit          m_err     = 0;
  int          m_waited  = 0;  // wait cycles without ack for current request
  logic [15:0] m_addr    = '0;
  logic [15:0] m_ir      = '0;
  bit          m_valid   = 0;

  task automatic model_reset();
    m_pending = 0; m_served = 0; m_err = 0; m_waited = 0;
    m_addr = '0; m_ir = '0; m_valid = 0;
  endtask

  task automatic model_step();
    if (m_pending) begin
      if (mem_bus.mem_ack) begin
        m_ir = mem_bus.mem_rdata; m_valid = 1; m_pending = 0; m_served = 1;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_pending = 0; m_err = 1;
        end
      end
    end else if (m_err) begin
      if (err_clr) m_err = 0;
    end else if (m_served) begin
      if (phase != 3'b000) m_served = 0;
    end else if (phase == 3'b000) begin
      m_pending = 1; m_addr = pc_in; m_valid = 0; m_waited = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge rst);
      if (!rst) model_reset();
      else      model_step();
      #1;
      chk("cyc mem_req",     {31'b0, mem_bus.mem_req}, {31'b0, m_pending});
      chk("cyc mem_addr",    {16'b0, mem_bus.mem_addr}, {16'b0, m_addr});
      chk("cyc ir",          {16'b0, ir}, {16'b0, m_ir});
      chk("cyc ir_valid",    {31'b0, ir_valid}, {31'b0, m_valid});
      chk("cyc fetch_err",   {31'b0, fetch_err}, {31'b0, m_err});
      chk("cyc fetch_stall", {31'b0, fetch_stall}, {31'b0, (phase == 3'b000) && !m_served});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    tick(1);
    chk("rst mem_req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("rst ir",        {16'b0, ir}, 32'd0);
    chk("rst ir_valid",  {31'b0, ir_valid}, 32'd0);
    chk("rst fetch_err", {31'b0, fetch_err}, 32'd0);
    rst = 1'b1;
    tick(1);

    // 1: ack tied high
    phase = 3'b000; pc_in = 16'h0005; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hA1B2;
    #1 chk("t1 stall before", {31'b0, fetch_stall}, 32'd1);
    tick(1);
    chk("t1 addr e1",  {16'b0, mem_bus.mem_addr}, 32'h0005);
    chk("t1 req e1",   {31'b0, mem_bus.mem_req}, 32'd1);
    chk("t1 stall e1", {31'b0, fetch_stall}, 32'd1);
    tick(1);
    chk("t1 ir e2",    {16'b0, ir}, 32'hA1B2);
    chk("t1 valid e2", {31'b0, ir_valid}, 32'd1);
    chk("t1 stall e2", {31'b0, fetch_stall}, 32'd0);
    chk("t1 req e2",   {31'b0, mem_bus.mem_req}, 32'd0);

    // 6: spurious ack in IDLE with FFFF
    phase = 3'b001; mem_bus.mem_rdata = 16'hFFFF;
    tick(3);
    chk("t6 idle ir", {16'b0, ir}, 32'hA1B2);

    // 2: ack delayed 3 cycles
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h1234; phase = 3'b000; pc_in = 16'h0010;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      pc_in = 16'h0099;
      tick(1);
      chk("t2 req wait",   {31'b0, mem_bus.mem_req}, 32'd1);
      chk("t2 addr wait",  {16'b0, mem_bus.mem_addr}, 32'h0010);
      chk("t2 stall wait", {31'b0, fetch_stall}, 32'd1);
      chk("t2 ir wait",    {16'b0, ir}, 32'hA1B2);
    end
    mem_bus.mem_ack = 1'b1;
    tick(1);
    chk("t2 ir ack",    {16'b0, ir}, 32'h1234);
    chk("t2 stall ack", {31'b0, fetch_stall}, 32'd0);

    // 3 + 6: phase held in fetch after DONE, spurious FFFF acks
    mem_bus.mem_rdata = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t3 no refetch", {31'b0, mem_bus.mem_req}, 32'd0);
      chk("t6 done ir",    {16'b0, ir}, 32'h1234);
    end
    phase = 3'b010;
    tick(1);
    phase = 3'b000; pc_in = 16'h0006; mem_bus.mem_rdata = 16'hBEEF;
    tick(1);
    chk("t3 addr next", {16'b0, mem_bus.mem_addr}, 32'h0006);
    tick(1);
    chk("t3 ir next", {16'b0, ir}, 32'hBEEF);

    // 4: timeout, then clear, then ack on the last cycle
    phase = 3'b001;
    tick(1);
    phase = 3'b000; pc_in = 16'h0020; mem_bus.mem_ack = 1'b0;
    tick(1 + TIMEOUT - 1);
    chk("t4 req before to", {31'b0, mem_bus.mem_req}, 32'd1);
    chk("t4 err before to", {31'b0, fetch_err}, 32'd0);
    tick(1);
    chk("t4 err",   {31'b0, fetch_err}, 32'd1);
    chk("t4 req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("t4 stall", {31'b0, fetch_stall}, 32'd1);
    tick(2);
    chk("t4 err held", {31'b0, fetch_err}, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4 err clr", {31'b0, fetch_err}, 32'd0);
    tick(1);
    chk("t4 refetch", {31'b0, mem_bus.mem_req}, 32'd1);
    tick(TIMEOUT - 1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h5555;
    tick(1);
    chk("t4 late ack ir",  {16'b0, ir}, 32'h5555);
    chk("t4 late ack err", {31'b0, fetch_err}, 32'd0);

    // 5: async reset mid-WAIT
    phase = 3'b001;
    tick(1);
    phase = 3'b000; pc_in = 16'h0030; mem_bus.mem_ack = 1'b0;
    tick(2);
    rst = 1'b0;
    #2;
    chk("t5 req",   {31'b0, mem_bus.mem_req}, 32'd0);
    chk("t5 valid", {31'b0, ir_valid}, 32'd0);
    chk("t5 ir",    {16'b0, ir}, 32'd0);
    chk("t5 err",   {31'b0, fetch_err}, 32'd0);
    tick(2);
    rst = 1'b1; pc_in = 16'h0031; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h7777;
    tick(1);
    chk("t5 addr restart", {16'b0, mem_bus.mem_addr}, 32'h0031);
    tick(1);
    chk("t5 ir restart", {16'b0, ir}, 32'h7777);
    phase = 3'b001;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
